// File: rtl/rv32_inst_encoder_if.sv
// Stream bundle for the RV32 instruction encoder: per-field input stream in,
// encoded instruction word stream out.
interface rv32_inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_format;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_error;

   modport master (
      output in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_error
   );

   modport slave (
      input  in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_error
   );
endinterface

// File: rtl/rv32_inst_encoder.sv
// Two-stage RV32 instruction encoder. S1 captures the encoded word and the
// immediate range error; S2 presents them downstream. Both stages advance
// together, so the pipeline stalls as a unit and bubbles are preserved.
module rv32_inst_encoder #(
   parameter bit ZERO_ON_ERROR = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   rv32_inst_encoder_if.slave bus
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic        adv;
   logic        s1_valid_q, s2_valid_q;
   logic [31:0] s1_inst_q, s2_inst_q;
   logic        s1_error_q, s2_error_q;
   logic [31:0] s1_inst_d;
   logic        s1_error_d;
   logic [31:0] imm;
   logic        imm12_ok, imm13_ok, imm21_ok;

   // out_ready reaches in_ready combinationally so a full pipe can take and
   // give a word in the same cycle.
   assign adv          = !s2_valid_q || bus.out_ready;
   assign bus.in_ready = adv;

   assign imm      = bus.in_imm;
   assign imm12_ok = (&imm[31:11]) || !(|imm[31:11]);
   assign imm13_ok = (&imm[31:12]) || !(|imm[31:12]);
   assign imm21_ok = (&imm[31:20]) || !(|imm[31:20]);

   // Field placement per format plus the range/legality error.
   always_comb begin
      s1_inst_d  = '0;
      s1_error_d = (bus.in_opcode[1:0] != 2'b11);
      case (bus.in_format)
         FMT_R: s1_inst_d = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             bus.in_rd, bus.in_opcode};
         FMT_I: begin
            s1_inst_d = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            if (!imm12_ok) s1_error_d = 1'b1;
         end
         FMT_S: begin
            s1_inst_d = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                         bus.in_opcode};
            if (!imm12_ok) s1_error_d = 1'b1;
         end
         FMT_B: begin
            s1_inst_d = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         imm[4:1], imm[11], bus.in_opcode};
            if (!imm13_ok || imm[0]) s1_error_d = 1'b1;
         end
         FMT_U: begin
            s1_inst_d = {imm[31:12], bus.in_rd, bus.in_opcode};
            if (imm[11:0] != 12'd0) s1_error_d = 1'b1;
         end
         FMT_J: begin
            s1_inst_d = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd,
                         bus.in_opcode};
            if (!imm21_ok || imm[0]) s1_error_d = 1'b1;
         end
         default: s1_error_d = 1'b1;
      endcase
      if (ZERO_ON_ERROR && s1_error_d) s1_inst_d = '0;
   end

   // S1: data only loads with a real transaction so idle bus contents never
   // leak into the held output.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_inst_q  <= '0;
         s1_error_q <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_inst_q  <= s1_inst_d;
            s1_error_q <= s1_error_d;
         end
      end
   end

   // S2: output register, held while downstream back-pressures.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_inst_q  <= '0;
         s2_error_q <= 1'b0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_inst_q  <= s1_inst_q;
            s2_error_q <= s1_error_q;
         end
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_inst  = s2_inst_q;
   assign bus.out_error = s2_error_q;

endmodule
